// File: rtl/isolation_tree_scorer.sv
// Isolation-tree anomaly scorer: walks a runtime-loaded binary tree one level
// per clock and flags samples whose isolation path is shorter than a limit.
module isolation_tree_scorer #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_FEAT = 2,
  parameter  int DEPTH    = 4,
  parameter  int COUNT_W  = 16,
  localparam int FSEL_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
  localparam int ADDR_W   = DEPTH,
  localparam int LEN_W    = $clog2(DEPTH + 1),
  localparam int NODES    = (1 << DEPTH) - 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [NUM_FEAT*DATA_W-1:0] i_in_data,
  input  logic [LEN_W-1:0]           i_anom_len_thresh,
  input  logic                       i_cfg_we,
  input  logic [ADDR_W-1:0]          i_cfg_addr,
  input  logic [FSEL_W-1:0]          i_cfg_feat,
  input  logic [DATA_W-1:0]          i_cfg_thresh,
  input  logic                       i_cfg_leaf,
  output logic                       o_cfg_ready,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_anomaly_detected,
  output logic [LEN_W-1:0]           o_path_len,
  output logic [COUNT_W-1:0]         o_anomaly_count
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t              r_state;
  state_t              w_next;

  logic [DATA_W-1:0]   r_feat [NUM_FEAT];
  logic [LEN_W-1:0]    r_limit;
  logic [LEN_W-1:0]    r_depth;
  logic [LEN_W-1:0]    r_len;
  logic                r_anom;
  logic [COUNT_W-1:0]  r_count;
  // One extra bit: children of the deepest readable level overflow ADDR_W.
  logic [ADDR_W:0]     r_node;

  logic                r_leafTab   [NODES];
  logic [FSEL_W-1:0]   r_featTab   [NODES];
  logic [DATA_W-1:0]   r_threshTab [NODES];

  logic [ADDR_W-1:0]   w_nodeIdx;
  logic                w_atMax;
  logic                w_term;
  logic [FSEL_W-1:0]   w_fsel;
  logic [DATA_W-1:0]   w_thr;
  logic                w_goLeft;

  assign w_nodeIdx = r_node[ADDR_W-1:0];
  assign w_atMax   = (r_depth == LEN_W'(DEPTH));

  // At maximum depth the table is not consulted; that case behaves as a leaf.
  always_comb begin
    w_term = 1'b1;
    w_fsel = '0;
    w_thr  = '0;
    if (!w_atMax && (w_nodeIdx < ADDR_W'(NODES))) begin
      w_term = r_leafTab[w_nodeIdx];
      w_thr  = r_threshTab[w_nodeIdx];
      if (int'(r_featTab[w_nodeIdx]) < NUM_FEAT) begin
        w_fsel = r_featTab[w_nodeIdx];
      end
    end
  end

  assign w_goLeft = (r_feat[w_fsel] < w_thr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_next = WALK;
      WALK:    if (w_term)     w_next = DONE;
      DONE:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_node  <= '0;
      r_depth <= '0;
      r_limit <= '0;
      r_len   <= '0;
      r_anom  <= 1'b0;
      r_count <= '0;
      for (int k = 0; k < NUM_FEAT; k++) begin
        r_feat[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
              r_feat[k] <= i_in_data[k*DATA_W +: DATA_W];
            end
            r_limit <= i_anom_len_thresh;
            r_node  <= '0;
            r_depth <= '0;
          end
        end
        WALK: begin
          if (w_term) begin
            r_len  <= r_depth;
            r_anom <= (r_depth < r_limit);
          end else begin
            r_node  <= (r_node << 1) + (w_goLeft ? (ADDR_W+1)'(1) : (ADDR_W+1)'(2));
            r_depth <= r_depth + LEN_W'(1);
          end
        end
        DONE: begin
          if (i_out_ready && r_anom && (r_count != {COUNT_W{1'b1}})) begin
            r_count <= r_count + COUNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Writes land only in IDLE, so a walk always sees a stable table.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int n = 0; n < NODES; n++) begin
        r_leafTab[n]   <= 1'b1;
        r_featTab[n]   <= '0;
        r_threshTab[n] <= '0;
      end
    end else if (i_cfg_we && (r_state == IDLE) && (i_cfg_addr < ADDR_W'(NODES))) begin
      r_leafTab[i_cfg_addr]   <= i_cfg_leaf;
      r_featTab[i_cfg_addr]   <= i_cfg_feat;
      r_threshTab[i_cfg_addr] <= i_cfg_thresh;
    end
  end

  assign o_in_ready         = (r_state == IDLE);
  assign o_cfg_ready        = (r_state == IDLE);
  assign o_out_valid        = (r_state == DONE);
  assign o_anomaly_detected = r_anom;
  assign o_path_len         = r_len;
  assign o_anomaly_count    = r_count;

endmodule

// File: tb/tb_isolation_tree_scorer.sv
// Self-checking bench for isolation_tree_scorer: randomized and directed samples
// compared against a tree-walk model; a 2-bit-counter twin checks saturation.
module tb_isolation_tree_scorer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [15:0] inData;
  logic [2:0]  limit;
  logic        cfgWe;
  logic [3:0]  cfgAddr;
  logic        cfgFeat;
  logic [7:0]  cfgThresh;
  logic        cfgLeaf;
  logic        outReady;

  logic        inReady, cfgReady, outValid, anomaly;
  logic [2:0]  pathLen;
  logic [15:0] count16;
  logic        satInReady, satCfgReady, satOutValid, satAnom;
  logic [2:0]  satLen;
  logic [1:0]  count2;

  always #5 clk = ~clk;

  isolation_tree_scorer dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_in_data(inData), .i_anom_len_thresh(limit), .i_cfg_we(cfgWe),
    .i_cfg_addr(cfgAddr), .i_cfg_feat(cfgFeat), .i_cfg_thresh(cfgThresh),
    .i_cfg_leaf(cfgLeaf), .o_cfg_ready(cfgReady), .o_out_valid(outValid),
    .i_out_ready(outReady), .o_anomaly_detected(anomaly), .o_path_len(pathLen),
    .o_anomaly_count(count16)
  );

  isolation_tree_scorer #(.COUNT_W(2)) dutSat (
    .i_clk(clk), .i_reset(reset), .i_in_valid(inValid), .o_in_ready(satInReady),
    .i_in_data(inData), .i_anom_len_thresh(limit), .i_cfg_we(cfgWe),
    .i_cfg_addr(cfgAddr), .i_cfg_feat(cfgFeat), .i_cfg_thresh(cfgThresh),
    .i_cfg_leaf(cfgLeaf), .o_cfg_ready(satCfgReady), .o_out_valid(satOutValid),
    .i_out_ready(outReady), .o_anomaly_detected(satAnom), .o_path_len(satLen),
    .o_anomaly_count(count2)
  );

  int checks = 0;
  int passes = 0;

  logic       mLeaf   [15];
  logic       mFeat   [15];
  logic [7:0] mThresh [15];
  int         modelCount;

  // Reference walk: follow the heap-ordered tree until a leaf or the depth cap.
  function automatic int modelLen(input logic [15:0] d);
    int node = 0;
    int depth = 0;
    logic [7:0] fv;
    while (depth < 4 && !mLeaf[node]) begin
      fv = mFeat[node] ? d[15:8] : d[7:0];
      node = (fv < mThresh[node]) ? 2 * node + 1 : 2 * node + 2;
      depth++;
    end
    return depth;
  endfunction

  function automatic int expCount(input int cap);
    return (modelCount > cap) ? cap : modelCount;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 15; i++) begin
      mLeaf[i] = 1'b1;
      mFeat[i] = 1'b0;
      mThresh[i] = 8'h00;
    end
    modelCount = 0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    modelReset();
    tick();
  endtask

  task automatic cfgWrite(input int addr, input int feat, input int thr, input int leaf);
    cfgWe = 1'b1;
    cfgAddr = 4'(addr);
    cfgFeat = 1'(feat);
    cfgThresh = 8'(thr);
    cfgLeaf = 1'(leaf);
    tick();
    cfgWe = 1'b0;
    if (addr < 15) begin
      mLeaf[addr] = 1'(leaf);
      mFeat[addr] = 1'(feat);
      mThresh[addr] = 8'(thr);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [2:0] lim);
    inValid = 1'b1;
    inData = d;
    limit = lim;
    tick();
    inValid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (outValid !== 1'b1 && lat <= 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input bit expAnom);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    if (expAnom) modelCount++;
  endtask

  task automatic test_reset();
    int lat;
    checks++; if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b expected 1", inReady); else passes++;
    checks++; if (cfgReady !== 1'b1) $display("[TB] FAIL reset_cfg_ready: got %0b expected 1", cfgReady); else passes++;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b expected 0", outValid); else passes++;
    checks++; if (anomaly !== 1'b0) $display("[TB] FAIL reset_anomaly: got %0b expected 0", anomaly); else passes++;
    checks++; if (pathLen !== 3'd0) $display("[TB] FAIL reset_path_len: got %0d expected 0", pathLen); else passes++;
    checks++; if (count16 !== 16'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count16); else passes++;
    applyStimulus(16'h3412, 3'd1);
    waitResult(lat);
    checks++; if (lat != 2) $display("[TB] FAIL reset_latency: got %0d expected 2", lat); else passes++;
    checks++; if (pathLen !== 3'd0) $display("[TB] FAIL reset_sample_len: got %0d expected 0", pathLen); else passes++;
    checks++; if (anomaly !== 1'b1) $display("[TB] FAIL reset_sample_anom: got %0b expected 1", anomaly); else passes++;
    handshake(1'b1);
    checks++; if (count16 !== 16'd1) $display("[TB] FAIL reset_sample_count: got %0d expected 1", count16); else passes++;
  endtask

  task automatic test_full_depth();
    logic [15:0] datas [4] = '{16'h00AB, 16'h00AB, 16'h0010, 16'h1280};
    logic [2:0]  lims  [4] = '{3'd4, 3'd5, 3'd0, 3'd7};
    int lat, expLen;
    bit expAnom;
    for (int a = 0; a < 15; a++) cfgWrite(a, 0, 8'h80, 0);
    for (int s = 0; s < 4; s++) begin
      expLen = modelLen(datas[s]);
      expAnom = expLen < int'(lims[s]);
      applyStimulus(datas[s], lims[s]);
      waitResult(lat);
      checks++; if (pathLen !== 3'(expLen)) $display("[TB] FAIL full_len[%0d]: got %0d expected %0d", s, pathLen, expLen); else passes++;
      checks++; if (anomaly !== expAnom) $display("[TB] FAIL full_anom[%0d]: got %0b expected %0b", s, anomaly, expAnom); else passes++;
      checks++; if (lat != expLen + 2) $display("[TB] FAIL full_latency[%0d]: got %0d expected %0d", s, lat, expLen + 2); else passes++;
      handshake(expAnom);
      checks++; if (count16 !== 16'(expCount(65535))) $display("[TB] FAIL full_count[%0d]: got %0d expected %0d", s, count16, expCount(65535)); else passes++;
    end
  endtask

  task automatic test_branching();
    logic [15:0] datas [3] = '{16'h1022, 16'h5022, 16'h5090};
    int wantLen [3] = '{1, 2, 2};
    int lat, expLen;
    bit expAnom;
    cfgWrite(0, 1, 8'h50, 0);
    cfgWrite(1, 0, 8'h00, 1);
    cfgWrite(2, 0, 8'h40, 0);
    cfgWrite(5, 0, 8'h00, 1);
    cfgWrite(6, 0, 8'h00, 1);
    for (int s = 0; s < 3; s++) begin
      expLen = modelLen(datas[s]);
      expAnom = expLen < 2;
      applyStimulus(datas[s], 3'd2);
      waitResult(lat);
      checks++; if (pathLen !== 3'(wantLen[s])) $display("[TB] FAIL branch_len[%0d]: got %0d expected %0d", s, pathLen, wantLen[s]); else passes++;
      checks++; if (anomaly !== expAnom) $display("[TB] FAIL branch_anom[%0d]: got %0b expected %0b", s, anomaly, expAnom); else passes++;
      checks++; if (lat != expLen + 2) $display("[TB] FAIL branch_latency[%0d]: got %0d expected %0d", s, lat, expLen + 2); else passes++;
      handshake(expAnom);
    end
  endtask

  task automatic test_backpressure();
    int lat, expLen;
    bit expAnom;
    logic [15:0] cntBefore;
    expLen = modelLen(16'h1022);
    expAnom = expLen < 3;
    applyStimulus(16'h1022, 3'd3);
    waitResult(lat);
    cntBefore = count16;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (outValid !== 1'b1) $display("[TB] FAIL bp_valid[%0d]: got %0b expected 1", c, outValid); else passes++;
      checks++; if (pathLen !== 3'(expLen)) $display("[TB] FAIL bp_len[%0d]: got %0d expected %0d", c, pathLen, expLen); else passes++;
      checks++; if (anomaly !== expAnom) $display("[TB] FAIL bp_anom[%0d]: got %0b expected %0b", c, anomaly, expAnom); else passes++;
      checks++; if (inReady !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d]: got %0b expected 0", c, inReady); else passes++;
      checks++; if (count16 !== cntBefore) $display("[TB] FAIL bp_count_hold[%0d]: got %0d expected %0d", c, count16, cntBefore); else passes++;
    end
    handshake(expAnom);
    checks++; if (count16 !== 16'(expCount(65535))) $display("[TB] FAIL bp_count: got %0d expected %0d", count16, expCount(65535)); else passes++;
    tick();
    checks++; if (count16 !== 16'(expCount(65535))) $display("[TB] FAIL bp_count_once: got %0d expected %0d", count16, expCount(65535)); else passes++;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL bp_valid_drop: got %0b expected 0", outValid); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] datas [3] = '{16'h1022, 16'h5090, 16'h5022};
    int lat, expLen;
    bit expAnom;
    outReady = 1'b1;
    for (int s = 0; s < 3; s++) begin
      expLen = modelLen(datas[s]);
      expAnom = expLen < 2;
      applyStimulus(datas[s], 3'd2);
      waitResult(lat);
      checks++; if (pathLen !== 3'(expLen)) $display("[TB] FAIL b2b_len[%0d]: got %0d expected %0d", s, pathLen, expLen); else passes++;
      checks++; if (lat != expLen + 2) $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", s, lat, expLen + 2); else passes++;
      tick();
      if (expAnom) modelCount++;
      checks++; if (inReady !== 1'b1) $display("[TB] FAIL b2b_in_ready[%0d]: got %0b expected 1", s, inReady); else passes++;
      checks++; if (count16 !== 16'(expCount(65535))) $display("[TB] FAIL b2b_count[%0d]: got %0d expected %0d", s, count16, expCount(65535)); else passes++;
    end
    outReady = 1'b0;
  endtask

  task automatic test_cfg_gating();
    int lat;
    pulseReset();
    applyStimulus(16'h0010, 3'd7);
    cfgWe = 1'b1; cfgAddr = 4'd0; cfgFeat = 1'b0; cfgThresh = 8'h80; cfgLeaf = 1'b0;
    tick();
    cfgWe = 1'b0;
    checks++; if (outValid !== 1'b1 || pathLen !== 3'd0) $display("[TB] FAIL gate_first: got valid %0b len %0d expected valid 1 len 0", outValid, pathLen); else passes++;
    handshake(1'b1);
    applyStimulus(16'h0010, 3'd7);
    waitResult(lat);
    checks++; if (pathLen !== 3'(modelLen(16'h0010))) $display("[TB] FAIL gate_dropped_len: got %0d expected %0d", pathLen, modelLen(16'h0010)); else passes++;
    handshake(1'b1);
    cfgWe = 1'b1; cfgAddr = 4'd0; cfgFeat = 1'b0; cfgThresh = 8'h80; cfgLeaf = 1'b0;
    inValid = 1'b1; inData = 16'h0010; limit = 3'd7;
    tick();
    cfgWe = 1'b0; inValid = 1'b0;
    mLeaf[0] = 1'b0; mFeat[0] = 1'b0; mThresh[0] = 8'h80;
    waitResult(lat);
    checks++; if (pathLen !== 3'd1) $display("[TB] FAIL gate_same_cycle_len: got %0d expected 1", pathLen); else passes++;
    checks++; if (lat != 3) $display("[TB] FAIL gate_same_cycle_latency: got %0d expected 3", lat); else passes++;
    handshake(1'b1);
    checks++; if (count16 !== 16'(expCount(65535))) $display("[TB] FAIL gate_count: got %0d expected %0d", count16, expCount(65535)); else passes++;
  endtask

  task automatic test_random();
    int lat, expLen, hold;
    bit expAnom;
    logic [15:0] d;
    logic [2:0] lim;
    for (int w = 0; w < 25; w++) begin
      cfgWrite($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    for (int s = 0; s < 25; s++) begin
      d = 16'($urandom);
      lim = 3'($urandom_range(0, 7));
      hold = $urandom_range(0, 2);
      expLen = modelLen(d);
      expAnom = expLen < int'(lim);
      applyStimulus(d, lim);
      waitResult(lat);
      for (int h = 0; h < hold; h++) tick();
      checks++; if (pathLen !== 3'(expLen)) $display("[TB] FAIL rand_len[%0d]: got %0d expected %0d", s, pathLen, expLen); else passes++;
      checks++; if (anomaly !== expAnom) $display("[TB] FAIL rand_anom[%0d]: got %0b expected %0b", s, anomaly, expAnom); else passes++;
      checks++; if (lat != expLen + 2) $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", s, lat, expLen + 2); else passes++;
      checks++; if ({satInReady, satCfgReady, satOutValid, satAnom, satLen} !== {1'b0, 1'b0, 1'b1, expAnom, 3'(expLen)})
        $display("[TB] FAIL rand_twin[%0d]: got %b expected %b", s, {satInReady, satCfgReady, satOutValid, satAnom, satLen}, {1'b0, 1'b0, 1'b1, expAnom, 3'(expLen)}); else passes++;
      handshake(expAnom);
      checks++; if (count16 !== 16'(expCount(65535))) $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", s, count16, expCount(65535)); else passes++;
    end
  endtask

  task automatic test_saturation();
    int lat;
    pulseReset();
    for (int s = 0; s < 5; s++) begin
      applyStimulus(16'($urandom), 3'd7);
      waitResult(lat);
      handshake(1'b1);
      checks++; if (count2 !== 2'(expCount(3))) $display("[TB] FAIL sat_count2[%0d]: got %0d expected %0d", s, count2, expCount(3)); else passes++;
    end
    checks++; if (count16 !== 16'd5) $display("[TB] FAIL sat_count16: got %0d expected 5", count16); else passes++;
  endtask

  task automatic test_mid_reset();
    int lat;
    pulseReset();
    for (int a = 0; a < 15; a++) cfgWrite(a, 0, 8'h80, 0);
    applyStimulus(16'h00AB, 3'd7);
    waitResult(lat);
    handshake(1'b1);
    checks++; if (count16 !== 16'd1) $display("[TB] FAIL mid_pre_count: got %0d expected 1", count16); else passes++;
    applyStimulus(16'h00AB, 3'd7);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL mid_valid: got %0b expected 0", outValid); else passes++;
    checks++; if (inReady !== 1'b1) $display("[TB] FAIL mid_state_idle: got %0b expected 1", inReady); else passes++;
    checks++; if (count16 !== 16'd0 || count2 !== 2'd0) $display("[TB] FAIL mid_count: got %0d/%0d expected 0/0", count16, count2); else passes++;
    tick();
    reset = 1'b0;
    modelReset();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (outValid !== 1'b0 || inReady !== 1'b1) $display("[TB] FAIL mid_after[%0d]: got valid %0b ready %0b expected 0 1", c, outValid, inReady); else passes++;
    end
    applyStimulus(16'h00AB, 3'd7);
    waitResult(lat);
    checks++; if (pathLen !== 3'(modelLen(16'h00AB))) $display("[TB] FAIL mid_table_reset: got %0d expected %0d", pathLen, modelLen(16'h00AB)); else passes++;
    handshake(1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    inValid = 1'b0; inData = '0; limit = '0;
    cfgWe = 1'b0; cfgAddr = '0; cfgFeat = 1'b0; cfgThresh = '0; cfgLeaf = 1'b0;
    outReady = 1'b0;
    modelReset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_full_depth();
    test_branching();
    test_backpressure();
    test_back_to_back();
    test_cfg_gating();
    test_random();
    test_saturation();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
